// File: rtl/hazard_unit.sv
// Hazard detection for the 5-stage MIPS pipeline. It stalls the PC and IF/ID, bubbles ID/EX and flushes IF/ID.
// A two-state FSM adds the extra stall cycle needed by a branch on a load; saturating counters track stalls and flushes.
module hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             id_ex_memRead,
    input  logic             id_ex_regWrite,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             ex_mem_memRead,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             clr_cnt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {IDLE, STALL2} state_t;

    state_t state_reg;

    logic match_ex;
    logic match_mem;
    logic hz_lu;
    logic hz_ba;
    logic hz_bl1;
    logic hz_bl2;
    logic hz;
    logic stall;
    logic flush;

    // $0 is hardwired to zero, so a zero destination never creates a dependency.
    assign match_ex  = (id_ex_rd != '0) &&
                       ((id_ex_rd == if_id_rs && id_uses_rs) || (id_ex_rd == if_id_rt && id_uses_rt));
    assign match_mem = (ex_mem_rd != '0) &&
                       ((ex_mem_rd == if_id_rs && id_uses_rs) || (ex_mem_rd == if_id_rt && id_uses_rt));

    assign hz_lu  = id_ex_memRead && match_ex;
    assign hz_ba  = id_branch && id_ex_regWrite && !id_ex_memRead && match_ex;
    assign hz_bl1 = id_branch && id_ex_memRead && match_ex;
    assign hz_bl2 = id_branch && ex_mem_memRead && match_mem;
    assign hz     = hz_lu || hz_ba || hz_bl1 || hz_bl2;

    // Gating with rst_n keeps the pipeline free-running while reset is held.
    assign stall = rst_n && ((state_reg == IDLE && hz) || (state_reg == STALL2));
    assign flush = rst_n && (branch_taken || jump) && !stall;

    assign pc_write     = !stall;
    assign if_id_write  = !stall;
    assign id_ex_bubble = stall;
    assign if_id_flush  = flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_reg <= hz_bl1 ? STALL2 : IDLE;
                STALL2:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc = {flush, stall};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (clr_cnt) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];

endmodule

// File: doc/hazard_unit.md
# hazard_unit

- Pipeline hazard detection and control unit for the 5-stage MIPS core.
- Sits in the ID stage and works alongside the forwarding unit. The forwarding unit resolves dependencies by selecting bypass data. This block handles the cases bypassing cannot cover: it stalls the PC and IF/ID, inserts bubbles into ID/EX, and flushes IF/ID on taken branches and jumps.
- A small FSM sequences multi-cycle stalls. Saturating counters record stall and flush cycles for performance analysis.

## Interface
Parameters:
- REG_W, default 5, register specifier width
- CNT_W, default 32, performance counter width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- if_id_rs  in  REG_W  source 1 of the instruction in ID
- if_id_rt  in  REG_W  source 2 of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_branch  in  1  ID instruction is a beq/bne compared in ID
- id_ex_memRead  in  1  EX instruction is a load
- id_ex_regWrite  in  1  EX instruction writes a register
- id_ex_rd  in  REG_W  EX destination (already muxed rt/rd)
- ex_mem_memRead  in  1  MEM instruction is a load
- ex_mem_rd  in  REG_W  MEM destination
- branch_taken  in  1  ID branch resolved taken this cycle
- jump  in  1  ID instruction is j/jal/jr
- clr_cnt  in  1  synchronous clear of both counters
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- id_ex_bubble  out  1  zero the ID/EX control fields
- if_id_flush  out  1  clear IF/ID to a nop
- stall_cnt  out  CNT_W  stall cycles since reset/clear
- flush_cnt  out  CNT_W  flush cycles since reset/clear

## Operation
**Match rules**
- A match requires a nonzero destination equal to a used source: (rd == if_id_rs && id_uses_rs) || (rd == if_id_rt && id_uses_rt).
- Register $0 never produces a hazard.

**Combinational hazard, hz (evaluated only in IDLE)**
- LU (load-use): id_ex_memRead && match(id_ex_rd). Total 1 stall cycle.
- BA (branch on ALU result in EX): id_branch && id_ex_regWrite && !id_ex_memRead && match(id_ex_rd). Total 1 cycle.
- BL1 (branch on load in EX): id_branch && id_ex_memRead && match(id_ex_rd). Total 2 cycles.
- BL2 (branch on load in MEM): id_branch && ex_mem_memRead && match(ex_mem_rd). Total 1 cycle.

**FSM states**
- IDLE: hz = LU|BA|BL1|BL2.
  - If BL1, go to STALL2.
  - Otherwise stay in IDLE.
- STALL2: forced stall for one cycle. All hazard inputs are ignored. Always returns to IDLE.

**Stall and flush outputs**
- stall = hz (in IDLE) or (state == STALL2).
- While stall: pc_write=0, if_id_write=0, id_ex_bubble=1.
- if_id_flush = (branch_taken || jump) && !stall.
- Stall has priority over flush. A branch is never resolved on stale operands, so no flush is issued during a stall cycle.
- A flush does not stall: pc_write=1, if_id_write=1 (the flush clear overrides the load).

**Counters**
- stall_cnt increments on each cycle with stall=1.
- flush_cnt increments on each cycle with if_id_flush=1.
- Both saturate at all ones and never wrap.
- clr_cnt zeroes both counters on the next edge. clr_cnt has priority over increment in the same cycle.

## Timing
- Stall and flush outputs are combinational from the inputs and the current state, valid in the same cycle the hazard is presented.
- Counters and state are registered and update on the rising clk edge.

**Reset**
- rst_n low: state=IDLE, stall_cnt=0, flush_cnt=0, asynchronously.
- While rst_n is low, outputs are forced to pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
- Reset asserted mid-STALL2 aborts the stall immediately.

**Stall lengths**
- LU, BA, BL2: stall high for exactly 1 cycle. On the next cycle the producer has advanced and the hazard no longer matches.
- BL1: stall high for 2 consecutive cycles (IDLE with hz, then STALL2), then IDLE.
  - In STALL2 the load sits in MEM, which would also match BL2. The FSM exits STALL2 after one cycle, so it must not add a third cycle.

**Other timing**
- Back-to-back hazards: a new hazard detected in the first IDLE cycle after a stall stalls again, with no gap cycle required.
- Counter saturation: at stall_cnt = 2^CNT_W-1 with stall=1, the value holds.

## Test plan
- **Load-use:** lw $2 in EX (id_ex_memRead=1, id_ex_rd=2), ID add with rs=2, id_uses_rs=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle; stall_cnt 0->1.
- **Zero register:** same as load-use but id_ex_rd=0 and rs=0 -> no stall; stall_cnt stays 0.
- **Branch on load:** id_branch=1, rt=5, lw $5 in EX -> stall for 2 cycles (second cycle from STALL2 even though ex_mem_memRead=1, ex_mem_rd=5), then pc_write=1; stall_cnt=2.
- **Stall vs flush priority:** branch_taken=1 together with a BA hazard (id_ex_rd=7, rs=7) -> cycle 1: stall, if_id_flush=0; cycle 2: hazard gone, branch_taken=1 -> if_id_flush=1, flush_cnt=1.
- **Jump:** jump=1 with no hazard -> if_id_flush=1, pc_write=1 for 1 cycle.
- **Reset mid-stall and saturation:** rst_n low during STALL2 -> state=IDLE, counters=0, pc_write=1 at once. Separately, with CNT_W=4: 16 consecutive stall cycles -> stall_cnt=15; clr_cnt=1 -> stall_cnt=0 on the next edge.
